// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding, frame constants, parity helper.
// Imported by the transmit and receive stages so both sides agree on framing.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 5208;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic uart_even_parity(input logic [UART_DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a byte source and the UART transmitter.
// master = byte source, slave = uart_tx; transfer on tx_valid && tx_ready.
interface uart_tx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] tx_data;
    logic                      tx_valid;
    logic                      tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the last count.
// Latency: tick is combinational from the counter; clear holds the counter at zero.
// Backpressure: none; free-running whenever clear is low.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int             CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // Wrapping on tick is what restarts the count at each new state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter (8E1 when UART_TX_PARITY_EN is defined), LSB first on dcom.
// Latency: start bit appears on dcom one cycle after the accepting edge; frame = 10 (11) bit times.
// Backpressure: tx_ready is high only in IDLE; a held tx_valid waits until the frame completes.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic        clk,
    input  logic        rst_n,
    uart_tx_if.slave    tx,
    output logic        dcom,
    output logic        busy
);

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t            state;
    logic [UART_DATA_BITS-1:0] shift;
    logic [2:0]                bit_cnt;
    logic                      tx_ready_q;
    logic                      tick;
    logic                      baud_clear;
    logic                      accept;

    assign accept      = tx.tx_valid && tx_ready_q;
    assign tx.tx_ready = tx_ready_q;

    // Timer is parked at zero while idle so the start bit gets a full period.
    assign baud_clear = (state == IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (baud_clear),
        .tick  (tick)
    );

`ifdef UART_TX_PARITY_EN
    logic par_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bit <= 1'b0;
        end else if (accept) begin
            par_bit <= uart_even_parity(tx.tx_data);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift      <= '0;
            bit_cnt    <= '0;
            dcom       <= 1'b1;
            tx_ready_q <= 1'b1;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift      <= tx.tx_data;
                        bit_cnt    <= '0;
                        dcom       <= 1'b0;
                        tx_ready_q <= 1'b0;
                        busy       <= 1'b1;
                        state      <= START;
                    end
                end

                START: begin
                    if (tick) begin
                        dcom  <= shift[0];
                        state <= DATA;
                    end
                end

                DATA: begin
                    if (tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            dcom    <= par_bit;
                            state   <= PARITY;
`else
                            dcom    <= 1'b1;
                            state   <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            // dcom takes the next bit in the same edge the register shifts.
                            shift   <= {1'b0, shift[UART_DATA_BITS-1:1]};
                            dcom    <= shift[1];
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        dcom  <= 1'b1;
                        state <= STOP;
                    end
                end
`endif

                STOP: begin
                    if (tick) begin
                        dcom       <= 1'b1;
                        tx_ready_q <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: begin
                    dcom       <= 1'b1;
                    tx_ready_q <= 1'b1;
                    busy       <= 1'b0;
                    bit_cnt    <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
